// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the TL transmit arbiter.
package tx_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_SOURCES = 4;
  localparam int DEF_FIFO_DEPTH  = 8;

  localparam int SRC_A2P_RD     = 0;
  localparam int SRC_A2P_WR     = 1;
  localparam int SRC_MASTER_CPL = 2;
  localparam int SRC_RX_ROUTER  = 3;

endpackage

// File: rtl/tx_seq_arbiter_if.sv
// Source-buffer / assembler side signals of the transmit arbiter.
interface tx_seq_arbiter_if
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = DEF_NUM_SOURCES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SEL_W       = $clog2(NUM_SOURCES)
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SOURCES-1:0] src_valid;
  logic [NUM_SOURCES-1:0] fc_ok;
  logic                   tx_done;
  logic [NUM_SOURCES-1:0] src_grant;
  logic [SEL_W-1:0]       arb_sel;
  logic                   arb_busy;
  logic [CNT_W-1:0]       order_count;
  logic                   order_full;
  logic                   order_empty;

  modport master (
    output src_valid, fc_ok, tx_done,
    input  src_grant, arb_sel, arb_busy, order_count, order_full, order_empty
  );

  modport slave (
    input  src_valid, fc_ok, tx_done,
    output src_grant, arb_sel, arb_busy, order_count, order_full, order_empty
  );
endinterface

// File: rtl/tx_order_fifo.sv
// Arrival-order FIFO of multi-hot source masks; head bits can be cleared in place.
module tx_order_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          clr_en,
  input  logic [W-1:0]  clr_mask,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      // A push can only land on the head slot when that slot is being popped.
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      else if (clr_en)
        mem[rd_ptr] <= mem[rd_ptr] & ~clr_mask;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tx_seq_arbiter.sv
// Transmit arbiter: grants sources in arrival order, round-robin within a group, gated by credits.
module tx_seq_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = DEF_NUM_SOURCES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SEL_W       = $clog2(NUM_SOURCES)
) (
  input  logic            clk,
  input  logic            arst,
  tx_seq_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  arb_state_e             state;
  logic [NUM_SOURCES-1:0] pending, cap, head, cand, sel_oh;
  logic [SEL_W-1:0]       rr_ptr, sel;
  logic                   found, fire, pop, push, full, empty;

  assign cap  = bus.src_valid & ~pending;
  assign cand = empty ? '0 : (head & bus.fc_ok);
  assign fire = found && ((state == IDLE) || bus.tx_done);

  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SOURCES;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = SEL_W'(idx);
      end
    end
  end

  assign sel_oh = NUM_SOURCES'(1) << sel;
  assign pop    = fire && ((head & ~sel_oh) == '0);
  assign push   = (cap != '0) && (!full || pop);

  tx_order_fifo #(.W(NUM_SOURCES), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (arst),
    .push      (push),
    .push_data (cap),
    .pop       (pop),
    .clr_en    (fire),
    .clr_mask  (sel_oh),
    .head      (head),
    .count     (bus.order_count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.order_full  = full;
  assign bus.order_empty = empty;
  assign bus.arb_busy    = (state == BUSY);

  // Pending stays set through the grant cycle so a still-high valid is not re-captured there.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) pending <= '0;
    else       pending <= (pending & ~bus.src_grant) | (push ? cap : '0);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state         <= IDLE;
      bus.src_grant <= '0;
      bus.arb_sel   <= '0;
      rr_ptr        <= '0;
    end else begin
      bus.src_grant <= '0;
      if (fire) begin
        bus.src_grant <= sel_oh;
        bus.arb_sel   <= sel;
        rr_ptr        <= (sel == SEL_W'(NUM_SOURCES-1)) ? '0 : sel + 1'b1;
        state         <= BUSY;
      end else if (state == BUSY && bus.tx_done) begin
        state         <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_tx_seq_arbiter.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_tx_seq_arbiter;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  tx_seq_arbiter_if #(.NUM_SOURCES(N), .FIFO_DEPTH(D)) bus ();

  tx_seq_arbiter #(.NUM_SOURCES(N), .FIFO_DEPTH(D)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: order list of arrival masks, pending set, rr pointer, busy flag.
  bit [N-1:0] mq[$];
  bit [N-1:0] m_pend, m_grant;
  int         m_sel, m_rr;
  bit         m_busy;
  bit         rnd_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = '0; m_grant = '0; m_sel = 0; m_rr = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] v, fc, head, cand, oh, cap, tmp;
    bit td, fire, pop, push;
    int sel;
    v = bus.src_valid; fc = bus.fc_ok; td = bus.tx_done;
    head = (mq.size() > 0) ? mq[0] : '0;
    cand = head & fc;
    sel = -1;
    for (int k = 0; k < N; k++)
      if (sel < 0 && cand[(m_rr + k) % N]) sel = (m_rr + k) % N;
    fire = (sel >= 0) && (!m_busy || td);
    oh = '0;
    if (sel >= 0) oh[sel] = 1'b1;
    pop  = fire && ((head & ~oh) == '0);
    cap  = v & ~m_pend;
    push = (cap != '0) && (mq.size() < D || pop);
    m_pend = (m_pend & ~m_grant) | (push ? cap : '0);
    if (fire) begin
      tmp = mq[0]; tmp[sel] = 1'b0; mq[0] = tmp;
      if (pop) void'(mq.pop_front());
    end
    if (push) mq.push_back(cap);
    if (fire) begin
      m_grant = oh; m_sel = sel; m_rr = (sel + 1) % N; m_busy = 1;
    end else begin
      m_grant = '0;
      if (m_busy && td) m_busy = 0;
    end
  endtask

  task automatic check_model();
    chk("grant",  bus.src_grant, m_grant);
    chk("sel",    bus.arb_sel, m_sel);
    chk("busy",   bus.arb_busy, m_busy);
    chk("count",  bus.order_count, mq.size());
    chk("full",   bus.order_full, mq.size() == D);
    chk("empty",  bus.order_empty, mq.size() == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    for (int i = 0; i < N; i++)
      if (m_grant[i] && !(rnd_mode && $urandom_range(3) == 0)) bus.src_valid[i] = 1'b0;
  endtask

  task automatic pulse_td();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, bus.src_grant, 0);
    chk({tag, "_sel"},   bus.arb_sel, 0);
    chk({tag, "_busy"},  bus.arb_busy, 0);
    chk({tag, "_count"}, bus.order_count, 0);
    chk({tag, "_empty"}, bus.order_empty, 1);
    chk({tag, "_full"},  bus.order_full, 0);
  endtask

  task automatic do_reset();
    bus.src_valid = '0; bus.fc_ok = '1; bus.tx_done = 1'b0;
    arst = 1'b0;
    #1;
    model_reset();
    check_reset_vals("rst");
    @(negedge clk);
    arst = 1'b1;
  endtask

  initial begin
    bus.src_valid = '0; bus.fc_ok = '1; bus.tx_done = 1'b0;
    #12;
    do_reset();

    // Single request: grant visible two cycles after valid rises.
    bus.src_valid = 4'b0100;
    step();
    chk("t1_count1", bus.order_count, 1);
    step();
    chk("t1_grant", bus.src_grant, 4'b0100);
    chk("t1_sel", bus.arb_sel, 2);
    chk("t1_busy", bus.arb_busy, 1);
    step(); step();
    chk("t1_busy_hold", bus.arb_busy, 1);
    chk("t1_sel_hold", bus.arb_sel, 2);
    pulse_td();
    chk("t1_busy_fall", bus.arb_busy, 0);

    // Simultaneous arrival resolved round-robin from 0.
    do_reset();
    bus.src_valid = 4'b1001;
    step(); step();
    chk("t2_grant0", bus.src_grant, 4'b0001);
    pulse_td();
    chk("t2_grant3", bus.src_grant, 4'b1000);
    chk("t2_busy", bus.arb_busy, 1);
    chk("t2_count", bus.order_count, 0);
    pulse_td();

    // Arrival order beats index.
    do_reset();
    bus.src_valid = 4'b0010;
    step();
    bus.src_valid = 4'b0011;
    step();
    chk("t3_grant1", bus.src_grant, 4'b0010);
    pulse_td();
    chk("t3_grant0", bus.src_grant, 4'b0001);
    pulse_td();

    // Full order FIFO: third source held until a pop frees a slot.
    do_reset();
    bus.fc_ok = 4'b0000;
    bus.src_valid = 4'b0001; step();
    bus.src_valid = 4'b0011; step();
    bus.src_valid = 4'b0111; step();
    chk("t4_full", bus.order_full, 1);
    chk("t4_count", bus.order_count, 2);
    step();
    chk("t4_nogrant", bus.src_grant, 0);
    bus.fc_ok = 4'b1111;
    step();
    chk("t4_grant0", bus.src_grant, 4'b0001);
    chk("t4_refill", bus.order_count, 2);
    pulse_td();
    chk("t4_grant1", bus.src_grant, 4'b0010);
    pulse_td();
    chk("t4_grant2", bus.src_grant, 4'b0100);
    chk("t4_drain", bus.order_empty, 1);
    pulse_td();

    // Credit head-of-line blocking.
    do_reset();
    bus.fc_ok = 4'b1011;
    bus.src_valid = 4'b0100; step();
    bus.src_valid = 4'b0101; step();
    for (int c = 0; c < 10; c++) begin
      chk("t5_hol", bus.src_grant, 0);
      step();
    end
    bus.fc_ok = 4'b1111;
    step();
    chk("t5_grant2", bus.src_grant, 4'b0100);
    pulse_td();
    chk("t5_grant0", bus.src_grant, 4'b0001);
    pulse_td();

    // Reset while busy; held valids re-captured after release.
    do_reset();
    bus.src_valid = 4'b0011;
    step(); step();
    chk("t6_grant0", bus.src_grant, 4'b0001);
    bus.src_valid = 4'b0110;
    #2 arst = 1'b0;
    #1;
    model_reset();
    check_reset_vals("t6_async");
    @(negedge clk);
    arst = 1'b1;
    step();
    chk("t6_recap", bus.order_count, 1);
    step();
    chk("t6_grant1", bus.src_grant, 4'b0010);
    chk("t6_sel", bus.arb_sel, 1);
    pulse_td();
    chk("t6_grant2", bus.src_grant, 4'b0100);
    pulse_td();

    // Randomised traffic against the model.
    do_reset();
    rnd_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!bus.src_valid[i] && $urandom_range(3) == 0) bus.src_valid[i] = 1'b1;
      if ($urandom_range(3) == 0) bus.fc_ok = N'($urandom | $urandom);
      bus.tx_done = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      step();
    end
    bus.tx_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
